// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises RXD, samples each bit mid-period, and hands
// completed bytes to the consumer through a 1-entry valid/ready holding register.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 87,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       RX_BUSY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  input  logic       CLR_ERR,
  output logic [2:0] DBG_STATE
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxd_s;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_byte_done;
  logic          w_frame_err;
  logic          w_load;

  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_overrun;
  logic          r_frame_err;

  // Synchroniser resets to the idle (high) level so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (!RESET) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], RXD};
  end

  assign w_rxd_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_byte_done = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxd_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        // A start bit that is high again by mid-bit was a glitch.
        if (r_cnt == HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_rxd_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxd_s, r_shift[7:1]};
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt = '0;
          if (w_rxd_s) begin
            w_byte_done = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (w_rxd_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake: a byte transfers on any cycle with RX_VALID & RX_READY; the
  // holding register may reload in that same cycle, otherwise RX_VALID drops.
  assign w_load = w_byte_done & (~r_valid | RX_READY);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && RX_READY) begin
        r_valid <= 1'b0;
      end
      if (w_byte_done && !w_load) r_overrun <= 1'b1;
      else if (CLR_ERR)           r_overrun <= 1'b0;
    end
  end

  assign RX_DATA   = r_data;
  assign RX_VALID  = r_valid;
  assign RX_BUSY   = (r_state != S_IDLE);
  assign FRAME_ERR = r_frame_err;
  assign OVERRUN   = r_overrun;
  assign DBG_STATE = r_state;

endmodule
